inc_encoder_array: RTL and testbench
====================================

Name: inc_encoder_array

Overview:
Parametrised successor to the fixed 7-channel 16-bit incremental encoder group. It provides N_CH quadrature decoders, each with:
- an input synchroniser and glitch filter,
- a configurable-width signed position counter with wrap or saturate mode,
- illegal-transition detection,
- a per-channel synchronous clear.

All channel counts are captured in one coherent snapshot, triggered by the falling edge of the bus read strobe RD. The host interface therefore reads a consistent set of joint positions.

Parameters:
N_CH, 7, number of encoder channels (1..32)
CNT_W, 16, counter/output width per channel, two's complement (8..32)
FILT_LEN, 4, consecutive stable clk_encoder cycles required before a filtered input changes (1..255)
SAT_MODE, 0, 0 = counter wraps modulo 2^CNT_W; 1 = counter saturates at +2^(CNT_W-1)-1 / -2^(CNT_W-1)

Ports:
clk_encoder  in  1  sole clock; all logic is rising-edge
rst  in  1  synchronous reset, active-high
RD  in  1  asynchronous bus read strobe, active-low; falling edge requests a snapshot
chA  in  N_CH  quadrature channel A, bit i = channel i, asynchronous
chB  in  N_CH  quadrature channel B, bit i = channel i, asynchronous
clr  in  N_CH  synchronous per-channel counter clear, level, active-high
clr_err  in  1  clears all error flags, active-high
data_out  out  N_CH*CNT_W  snapshot; channel i occupies bits [i*CNT_W +: CNT_W]
snap_valid  out  1  one-cycle pulse, asserted in the cycle data_out updates
err  out  N_CH  sticky illegal-transition flag per channel

Behaviour:
- Synchronisers:
  - chA, chB and RD each pass through a 2-flop synchroniser.
  - These synchroniser flops are not reset.
- Glitch filter, per input (A and B per channel):
  - A counter of ceil(log2(FILT_LEN+1)) bits runs while the synchronised value differs from the filtered value.
  - The filtered value takes the synchronised value once the difference has persisted FILT_LEN consecutive cycles.
  - The counter returns to 0 on any cycle the two agree.
  - FILT_LEN=1 means the filtered value follows the synchronised value with 1 cycle delay.
- Reset (while rst=1):
  - Filtered registers load the synchronised inputs directly, with no count.
  - Filter counters, position counters, data_out, snap_valid and err are all 0.
  - The RD edge detector's previous-value register loads the synchronised RD, so no snapshot fires on reset release.
  - Reset must be held >=3 cycles.
  - Reset asserted mid-operation discards all counts and any pending snapshot.
- Decode, per channel: compare the filtered {A,B} with its value one cycle earlier.
  - Forward sequence 00->10->11->01->00: +1.
  - Reverse sequence: -1.
  - No change: hold.
  - Both bits change (00<->11, 10<->01): no count; err[i] <= 1.
  - x4 resolution: one count per filtered edge.
- Counter arithmetic:
  - SAT_MODE=0: +1 from 0x7FFF (CNT_W=16) gives 0x8000, and -1 from 0x8000 gives 0x7FFF.
  - SAT_MODE=1: the counter holds at its limit; err is not set on saturation.
- Clear:
  - clr[i]=1 sets counter i to 0 on the next edge.
  - If clr[i] and a step occur in the same cycle, the clear wins (result 0).
- Error flags:
  - err is sticky until clr_err=1.
  - If clr_err and a new illegal transition occur in the same cycle, err stays 1.
- Snapshot:
  - Snapshot event = synchronised RD was 1 in the previous cycle and is 0 in this cycle.
  - On the edge that ends the event cycle, all N_CH counters are copied to data_out simultaneously, and snap_valid pulses for the following cycle.
  - Latency from the RD falling edge at the pin to data_out valid: 3 clk_encoder cycles (+ metastability uncertainty of 1).
  - A snapshot coincident with clr captures the pre-clear value.
  - A snapshot coincident with a step captures the pre-step value.
  - data_out holds until the next snapshot; RD held low does not retrigger.
- Input rate:
  - No edge is lost provided each filtered input stays stable >= 1 cycle between changes.
  - Inputs must be stable >= FILT_LEN+3 cycles per quadrature state.

Test Plan:
1. Reset, then 10 forward cycles on ch0 (40 edges, 8 clocks per state, FILT_LEN=4), then RD low -> 3 cycles later data_out[15:0]=0x0028, all other channels 0, snap_valid one-cycle pulse, err=0.
2. 5 reverse quadrature cycles on ch3 from 0 -> snapshot reads 0xFFEC for ch3. With SAT_MODE=0 preloaded to 0x7FFF via +32767 steps, one more +1 -> 0x8000. Repeat with SAT_MODE=1 -> the counter stays at 0x7FFF.
3. 2-cycle pulses on chA[1] with chB steady (FILT_LEN=4) -> no count. 6-cycle pulse -> one +1 then one -1, net 0. Force 00->11 -> err[1]=1, count unchanged. clr_err -> err[1]=0.
4. clr[2] asserted in the same cycle as a +1 step on ch2 (value 5) -> counter 0. A snapshot in that same cycle reads 5, and the next snapshot reads 0.
5. All 7 channels moving at different rates, RD toggled every 50 cycles -> each data_out slice equals the reference-model count at the event cycle, and all slices come from the same cycle.
6. rst asserted mid-run with RD falling 1 cycle before it -> data_out=0, snap_valid never pulses. Inputs held at 11 through reset release -> counters remain 0.

Source files
------------

// File: rtl/inc_encoder_array.sv
// inc_encoder_array: bank of quadrature decoders with glitch filters
// and a coherent position snapshot on the falling edge of RD.
module inc_encoder_array #(
  parameter int N_CH     = 7,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int SAT_MODE = 0
) (
  input  logic                  clk_encoder,
  input  logic                  rst,
  input  logic                  RD,
  input  logic [N_CH-1:0]       chA,
  input  logic [N_CH-1:0]       chB,
  input  logic [N_CH-1:0]       clr,
  input  logic                  clr_err,
  output logic [N_CH*CNT_W-1:0] data_out,
  output logic                  snap_valid,
  output logic [N_CH-1:0]       err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILT_LEN - 1);
  localparam logic [FW-1:0] F_ONE = FW'(1);
  localparam logic [CNT_W-1:0] C_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] C_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam bit SAT = (SAT_MODE != 0);

  logic [N_CH-1:0] a_m;
  logic [N_CH-1:0] a_s;
  logic [N_CH-1:0] b_m;
  logic [N_CH-1:0] b_s;
  logic rd_m;
  logic rd_s;
  logic rd_q;
  logic snap;
  logic [N_CH*CNT_W-1:0] cnt_flat;

  // Synchronisers carry no reset so they track the pins at all times.
  always_ff @(posedge clk_encoder) begin
    a_m  <= chA;
    a_s  <= a_m;
    b_m  <= chB;
    b_s  <= b_m;
    rd_m <= RD;
    rd_s <= rd_m;
  end

  assign snap = rd_q & ~rd_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [FW-1:0]    ca;
    logic [FW-1:0]    cb;
    logic             fa;
    logic             fb;
    logic             pa;
    logic             pb;
    logic [1:0]       ic;
    logic [1:0]       ip;
    logic [1:0]       d;
    logic             up;
    logic             dn;
    logic             bad;
    logic [CNT_W-1:0] pos;
    logic             e;

    always_ff @(posedge clk_encoder) begin
      if (rst) begin
        fa <= a_s[i];
        ca <= '0;
      end else if (a_s[i] == fa) begin
        ca <= '0;
      end else if (ca == F_LAST) begin
        fa <= a_s[i];
        ca <= '0;
      end else begin
        ca <= ca + F_ONE;
      end
    end

    always_ff @(posedge clk_encoder) begin
      if (rst) begin
        fb <= b_s[i];
        cb <= '0;
      end else if (b_s[i] == fb) begin
        cb <= '0;
      end else if (cb == F_LAST) begin
        fb <= b_s[i];
        cb <= '0;
      end else begin
        cb <= cb + F_ONE;
      end
    end

    // Map {A,B} onto a 0..3 ring so the step is a 2-bit difference.
    assign ic = {fb, fa ^ fb};
    assign ip = {pb, pa ^ pb};
    assign d  = ic - ip;

    always_comb begin
      up  = 1'b0;
      dn  = 1'b0;
      bad = 1'b0;
      unique case (d)
        2'd1:    up  = 1'b1;
        2'd2:    bad = 1'b1;
        2'd3:    dn  = 1'b1;
        default: ;
      endcase
    end

    always_ff @(posedge clk_encoder) begin
      if (rst) begin
        pa  <= a_s[i];
        pb  <= b_s[i];
        pos <= '0;
        e   <= 1'b0;
      end else begin
        pa <= fa;
        pb <= fb;
        if (clr[i])
          pos <= '0;
        else if (up && !(SAT && pos == C_MAX))
          pos <= pos + C_ONE;
        else if (dn && !(SAT && pos == C_MIN))
          pos <= pos - C_ONE;
        if (bad)
          e <= 1'b1;
        else if (clr_err)
          e <= 1'b0;
      end
    end

    assign err[i] = e;
    assign cnt_flat[i*CNT_W +: CNT_W] = pos;
  end

  always_ff @(posedge clk_encoder) begin
    if (rst) begin
      rd_q       <= rd_s;
      data_out   <= '0;
      snap_valid <= 1'b0;
    end else begin
      rd_q       <= rd_s;
      snap_valid <= snap;
      if (snap)
        data_out <= cnt_flat;
    end
  end

endmodule

// File: tb/tb_inc_encoder_array.sv
// tb_inc_encoder_array: directed scenarios for the encoder bank,
// including an 8-bit pair (wrap vs saturate) sharing clock and RD.
module tb_inc_encoder_array;
  localparam int N = 7;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rd;
  logic clr_err;
  logic [N-1:0] cha;
  logic [N-1:0] chb;
  logic [N-1:0] clr;
  logic [N*W-1:0] dout;
  logic sv;
  logic [N-1:0] err;

  logic qa;
  logic qb;
  logic [7:0] w_out;
  logic [7:0] s_out;
  logic w_sv;
  logic s_sv;
  logic [0:0] w_err;
  logic [0:0] s_err;

  int errors = 0;
  int checks = 0;
  int cnt_m[N];
  logic [1:0] st[N];
  logic [1:0] qs;

  inc_encoder_array #(.N_CH(N), .CNT_W(W), .FILT_LEN(4), .SAT_MODE(0)) dut (
    .clk_encoder(clk), .rst(rst), .RD(rd), .chA(cha), .chB(chb),
    .clr(clr), .clr_err(clr_err), .data_out(dout), .snap_valid(sv),
    .err(err)
  );

  inc_encoder_array #(.N_CH(1), .CNT_W(8), .FILT_LEN(1), .SAT_MODE(0)) u_w (
    .clk_encoder(clk), .rst(rst), .RD(rd), .chA(qa), .chB(qb),
    .clr(1'b0), .clr_err(1'b0), .data_out(w_out), .snap_valid(w_sv),
    .err(w_err)
  );

  inc_encoder_array #(.N_CH(1), .CNT_W(8), .FILT_LEN(1), .SAT_MODE(1)) u_s (
    .clk_encoder(clk), .rst(rst), .RD(rd), .chA(qa), .chB(qb),
    .clr(1'b0), .clr_err(1'b0), .data_out(s_out), .snap_valid(s_sv),
    .err(s_err)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic move(input int ch, input int dir);
    st[ch] = 2'(st[ch] + ((dir > 0) ? 2'd1 : 2'd3));
    cnt_m[ch] += dir;
    cha[ch] = (st[ch] == 2'd1) || (st[ch] == 2'd2);
    chb[ch] = st[ch][1];
  endtask

  task automatic qmove(input int dir);
    qs = 2'(qs + ((dir > 0) ? 2'd1 : 2'd3));
    qa = (qs == 2'd1) || (qs == 2'd2);
    qb = qs[1];
  endtask

  function automatic logic [N*W-1:0] exp_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = 16'(cnt_m[i]);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    clr = '0;
    clr_err = 1'b0;
    rd = 1'b1;
    tick(4);
    rst = 1'b0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    tick(3);
  endtask

  task automatic do_snap(output logic [N*W-1:0] d, output logic [7:0] dw,
                         output logic [7:0] ds, output logic [4:0] h);
    rd = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      h[k] = sv;
      if (k == 2) begin
        d = dout;
        dw = w_out;
        ds = s_out;
      end
    end
    rd = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dout !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0", dout);
    end
    checks++;
    if (sv !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", sv);
    end
    checks++;
    if (err !== '0) begin
      errors++; $display("FAIL reset_err: got %b want 0", err);
    end
    checks++;
    if (w_out !== 8'h00 || s_out !== 8'h00) begin
      errors++; $display("FAIL reset_small: got %h/%h want 00", w_out, s_out);
    end
  endtask

  task automatic test_forward();
    logic [N*W-1:0] d;
    logic [7:0] dw, ds;
    logic [4:0] h;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      move(0, 1);
      tick(8);
    end
    tick(10);
    do_snap(d, dw, ds, h);
    checks++;
    if (d[15:0] !== 16'h0028) begin
      errors++; $display("FAIL fwd_ch0: got %h want 0028", d[15:0]);
    end
    checks++;
    if (d[N*W-1:16] !== '0) begin
      errors++; $display("FAIL fwd_others: got %h want 0", d[N*W-1:16]);
    end
    checks++;
    if (h !== 5'b00100) begin
      errors++; $display("FAIL fwd_pulse: got %b want 00100", h);
    end
    checks++;
    if (err !== '0) begin
      errors++; $display("FAIL fwd_err: got %b want 0", err);
    end
  endtask

  task automatic test_reverse_wrap();
    logic [N*W-1:0] d;
    logic [7:0] dw, ds;
    logic [4:0] h;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      move(3, -1);
      tick(8);
    end
    tick(10);
    do_snap(d, dw, ds, h);
    checks++;
    if (d[3*W +: W] !== 16'hFFEC) begin
      errors++; $display("FAIL rev_ch3: got %h want FFEC", d[3*W +: W]);
    end
    checks++;
    if (d !== exp_vec()) begin
      errors++; $display("FAIL rev_all: got %h want %h", d, exp_vec());
    end
    do_reset();
    for (int k = 0; k < 127; k++) begin
      qmove(1);
      tick(4);
    end
    tick(8);
    do_snap(d, dw, ds, h);
    checks++;
    if (dw !== 8'h7F || ds !== 8'h7F) begin
      errors++; $display("FAIL pos_max: got %h/%h want 7F/7F", dw, ds);
    end
    qmove(1);
    tick(8);
    do_snap(d, dw, ds, h);
    checks++;
    if (dw !== 8'h80 || ds !== 8'h7F) begin
      errors++; $display("FAIL pos_over: got %h/%h want 80/7F", dw, ds);
    end
    qmove(-1);
    tick(8);
    do_snap(d, dw, ds, h);
    checks++;
    if (dw !== 8'h7F || ds !== 8'h7E) begin
      errors++; $display("FAIL pos_back: got %h/%h want 7F/7E", dw, ds);
    end
    do_reset();
    for (int k = 0; k < 128; k++) begin
      qmove(-1);
      tick(4);
    end
    tick(8);
    do_snap(d, dw, ds, h);
    checks++;
    if (dw !== 8'h80 || ds !== 8'h80) begin
      errors++; $display("FAIL neg_min: got %h/%h want 80/80", dw, ds);
    end
    qmove(-1);
    tick(8);
    do_snap(d, dw, ds, h);
    checks++;
    if (dw !== 8'h7F || ds !== 8'h80) begin
      errors++; $display("FAIL neg_under: got %h/%h want 7F/80", dw, ds);
    end
    checks++;
    if (w_err !== 1'b0 || s_err !== 1'b0) begin
      errors++; $display("FAIL sat_err: got %b/%b want 0/0", w_err, s_err);
    end
  endtask

  task automatic test_glitch();
    logic [N*W-1:0] d;
    logic [7:0] dw, ds;
    logic [4:0] h;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cha[1] = 1'b1;
      tick(2);
      cha[1] = 1'b0;
      tick(12);
    end
    do_snap(d, dw, ds, h);
    checks++;
    if (d[W +: W] !== 16'h0000) begin
      errors++; $display("FAIL glitch_short: got %h want 0000", d[W +: W]);
    end
    cha[1] = 1'b1;
    tick(6);
    cha[1] = 1'b0;
    rd = 1'b0;
    tick(3);
    checks++;
    if (sv !== 1'b1 || dout[W +: W] !== 16'h0001) begin
      errors++; $display("FAIL glitch_mid: got %b/%h want 1/0001", sv, dout[W +: W]);
    end
    rd = 1'b1;
    tick(12);
    do_snap(d, dw, ds, h);
    checks++;
    if (d[W +: W] !== 16'h0000 || err !== '0) begin
      errors++; $display("FAIL glitch_net: got %h err %b want 0000 err 0", d[W +: W], err);
    end
    cha[1] = 1'b1;
    chb[1] = 1'b1;
    st[1] = 2'd2;
    tick(12);
    checks++;
    if (err !== 7'b0000010) begin
      errors++; $display("FAIL illegal_err: got %b want 0000010", err);
    end
    do_snap(d, dw, ds, h);
    checks++;
    if (d !== exp_vec()) begin
      errors++; $display("FAIL illegal_cnt: got %h want %h", d, exp_vec());
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    tick(1);
    checks++;
    if (err !== '0) begin
      errors++; $display("FAIL clr_err: got %b want 0", err);
    end
    cha[1] = 1'b0;
    chb[1] = 1'b0;
    st[1] = 2'd0;
    tick(6);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++;
    if (err[1] !== 1'b1) begin
      errors++; $display("FAIL err_priority: got %b want 1", err[1]);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  task automatic test_clear_snap();
    logic [N*W-1:0] d;
    logic [7:0] dw, ds;
    logic [4:0] h;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      move(2, 1);
      tick(8);
    end
    tick(10);
    move(2, 1);
    tick(4);
    rd = 1'b0;
    tick(2);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    checks++;
    if (sv !== 1'b1 || dout[2*W +: W] !== 16'h0005) begin
      errors++; $display("FAIL clr_snap: got %b/%h want 1/0005", sv, dout[2*W +: W]);
    end
    cnt_m[2] = 0;
    rd = 1'b1;
    tick(10);
    do_snap(d, dw, ds, h);
    checks++;
    if (d[2*W +: W] !== 16'h0000) begin
      errors++; $display("FAIL clr_wins: got %h want 0000", d[2*W +: W]);
    end
  endtask

  task automatic test_multi();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int t = 0; t < 50; t++) begin
        if (t < 30)
          for (int i = 0; i < N; i++)
            if (t % (8 + i) == 0) move(i, (i % 2 == 0) ? 1 : -1);
        if (t == 10) rd = 1'b1;
        if (t == 40) rd = 1'b0;
        tick(1);
        if (t == 42) begin
          checks++;
          if (sv !== 1'b1 || dout !== exp_vec()) begin
            errors++;
            $display("FAIL multi_p%0d: got %b/%h want 1/%h", p, sv, dout, exp_vec());
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N*W-1:0] d;
    logic [7:0] dw, ds;
    logic [4:0] h;
    int pulses;
    pulses = 0;
    rd = 1'b1;
    tick(4);
    rd = 1'b0;
    cha = '1;
    chb = '1;
    for (int i = 0; i < N; i++) st[i] = 2'd2;
    tick(1);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (sv) pulses++;
      if (k == 5) rst = 1'b0;
    end
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL midrst_pulse: got %0d want 0", pulses);
    end
    checks++;
    if (dout !== '0) begin
      errors++; $display("FAIL midrst_data: got %h want 0", dout);
    end
    rd = 1'b1;
    tick(4);
    do_snap(d, dw, ds, h);
    checks++;
    if (d !== '0 || err !== '0) begin
      errors++; $display("FAIL midrst_hold11: got %h err %b want 0", d, err);
    end
  endtask

  initial begin
    rst = 1'b1;
    rd = 1'b1;
    clr = '0;
    clr_err = 1'b0;
    cha = '0;
    chb = '0;
    qa = 1'b0;
    qb = 1'b0;
    qs = 2'd0;
    for (int i = 0; i < N; i++) begin
      st[i] = 2'd0;
      cnt_m[i] = 0;
    end
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_glitch();
    test_clear_snap();
    test_multi();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
